// File: rtl/dmem_port_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_port_arb_pkg
//  Brief    : Shared widths, FSM state encoding and the store-win helper for
//             the data-memory port arbiter.
//  Revision : 1.0
// ============================================================================
package dmem_port_arb_pkg;

    localparam int RV32_ADDR_WIDTH = 32;
    localparam int RV32_DATA_WIDTH = 32;
    localparam int DMARB_ST_W      = 2;

    typedef enum logic [DMARB_ST_W-1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FORCE = 2'd2
    } dmarb_state_t;

    // A flushed load is treated as absent, so it never blocks a pending store.
    function automatic logic dmarb_st_win(
        input dmarb_state_t state,
        input logic         st_req,
        input logic         ld_req_eff,
        input logic         stbuf_full
    );
        return st_req & ((state == S_FORCE) | stbuf_full | ~ld_req_eff);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_port_arb.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_port_arb
//  Brief    : Single-port dmem arbiter between the load path and the
//             committed-store drain, with starvation-forced store drains.
//  Revision : 1.0
// ============================================================================
module dmem_port_arb
    import dmem_port_arb_pkg::*;
#(
    parameter int STARVE_MAX = 8,
    parameter int CNT_W      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_flush,
    input  logic                       i_ld_req,
    input  logic [RV32_ADDR_WIDTH-1:0] i_ld_addr,
    output logic                       o_ld_gnt,
    output logic                       o_ld_stall,
    output logic [RV32_DATA_WIDTH-1:0] o_ld_rd_data,
    input  logic                       i_st_req,
    input  logic [RV32_ADDR_WIDTH-1:0] i_st_addr,
    input  logic [RV32_DATA_WIDTH-1:0] i_st_data,
    input  logic                       i_stbuf_full,
    output logic                       o_st_ack,
    output logic [RV32_ADDR_WIDTH-1:0] o_dmem_addr,
    output logic                       o_dmem_we,
    output logic [RV32_DATA_WIDTH-1:0] o_dmem_wdata,
    input  logic [RV32_DATA_WIDTH-1:0] i_dmem_rd_data
);

    localparam logic [CNT_W-1:0] c_starve_max = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

    dmarb_state_t     r_state;
    dmarb_state_t     w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_ld_eff;
    logic             w_st_win;
    logic             w_ld_win;

    assign w_ld_eff  = i_ld_req & ~i_flush;
    assign w_st_win  = dmarb_st_win(r_state, i_st_req, w_ld_eff, i_stbuf_full);
    assign w_ld_win  = w_ld_eff & ~w_st_win;
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + c_cnt_one;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (i_st_req && !w_st_win) begin
                    w_cnt_nxt   = c_cnt_one;
                    w_state_nxt = (c_cnt_one >= c_starve_max) ? S_FORCE : S_WAIT;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            S_WAIT: begin
                if (w_st_win || !i_st_req) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc >= c_starve_max) begin
                        w_state_nxt = S_FORCE;
                    end
                end
            end
            S_FORCE: begin
                // One forced drain only, unless the buffer is still full.
                w_cnt_nxt   = '0;
                w_state_nxt = (w_st_win && i_stbuf_full) ? S_FORCE : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Port outputs are held quiet while reset is asserted.
    assign o_st_ack     = rst_n & w_st_win;
    assign o_dmem_we    = rst_n & w_st_win;
    assign o_ld_gnt     = rst_n & w_ld_win;
    assign o_ld_stall   = rst_n & w_ld_eff & w_st_win;
    assign o_dmem_addr  = !rst_n ? '0 : (w_st_win ? i_st_addr : i_ld_addr);
    assign o_dmem_wdata = rst_n ? i_st_data : '0;
    assign o_ld_rd_data = i_dmem_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_port_arb
//  Brief    : Directed self-checking bench for dmem_port_arb with a small
//             asynchronous-read / clocked-write memory behind the port.
//  Revision : 1.0
// ============================================================================
module tb_dmem_port_arb;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        ld_gnt;
    logic        ld_stall;
    logic [31:0] ld_rd_data;
    logic        st_req;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        stbuf_full;
    logic        st_ack;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rd_data;

    logic [31:0] mem [0:255];

    int n_checks;
    int n_errors;

    dmem_port_arb #(.STARVE_MAX(8), .CNT_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_flush       (flush),
        .i_ld_req      (ld_req),
        .i_ld_addr     (ld_addr),
        .o_ld_gnt      (ld_gnt),
        .o_ld_stall    (ld_stall),
        .o_ld_rd_data  (ld_rd_data),
        .i_st_req      (st_req),
        .i_st_addr     (st_addr),
        .i_st_data     (st_data),
        .i_stbuf_full  (stbuf_full),
        .o_st_ack      (st_ack),
        .o_dmem_addr   (dmem_addr),
        .o_dmem_we     (dmem_we),
        .o_dmem_wdata  (dmem_wdata),
        .i_dmem_rd_data(dmem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dmem_rd_data = mem[dmem_addr[9:2]];
    always @(posedge clk) begin
        if (dmem_we) mem[dmem_addr[9:2]] <= dmem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of requests, check the grant outputs mid-cycle, then advance.
    task automatic cyc(input string tag, input logic l, input logic s, input logic f,
                       input logic fl, input logic e_gnt, input logic e_stall, input logic e_ack);
        ld_req     = l;
        st_req     = s;
        stbuf_full = f;
        flush      = fl;
        @(negedge clk);
        chk({tag, "_gnt"},   32'(ld_gnt),   32'(e_gnt));
        chk({tag, "_stall"}, 32'(ld_stall), 32'(e_stall));
        chk({tag, "_ack"},   32'(st_ack),   32'(e_ack));
        chk({tag, "_we"},    32'(dmem_we),  32'(e_ack));
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = 32'hDEADBEEF;

        // Reset: everything quiet even with all requests raised.
        rst_n      = 1'b0;
        ld_req     = 1'b1;
        st_req     = 1'b1;
        stbuf_full = 1'b1;
        flush      = 1'b0;
        ld_addr    = 32'h0000_0100;
        st_addr    = 32'h0000_0080;
        st_data    = 32'hA5A5_A5A5;
        @(negedge clk);
        chk("rst_gnt",   32'(ld_gnt),   32'h0);
        chk("rst_stall", 32'(ld_stall), 32'h0);
        chk("rst_ack",   32'(st_ack),   32'h0);
        chk("rst_we",    32'(dmem_we),  32'h0);
        chk("rst_addr",  dmem_addr,     32'h0);
        chk("rst_wdata", dmem_wdata,    32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Load only: data returned in the request cycle.
        ld_req = 1'b1; st_req = 1'b0; stbuf_full = 1'b0;
        @(negedge clk);
        chk("ld_rd_data", ld_rd_data, 32'hDEADBEEF);
        chk("ld_addr",    dmem_addr,  32'h0000_0100);
        @(posedge clk);
        #1;
        cyc("ld_only", 1, 0, 0, 0, 1, 0, 0);

        // Idle drain, then a same-address load sees the new data.
        st_addr = 32'h0000_0040;
        st_data = 32'h1234_5678;
        ld_req  = 1'b0; st_req = 1'b1;
        @(negedge clk);
        chk("drain_addr",  dmem_addr,  32'h0000_0040);
        chk("drain_wdata", dmem_wdata, 32'h1234_5678);
        chk("drain_ack",   32'(st_ack), 32'h1);
        @(posedge clk);
        #1;
        ld_addr = 32'h0000_0040;
        ld_req  = 1'b1; st_req = 1'b0;
        @(negedge clk);
        chk("raw_rd_data", ld_rd_data, 32'h1234_5678);
        chk("raw_gnt",     32'(ld_gnt), 32'h1);
        @(posedge clk);
        #1;

        // Idle port: mux selects the load address, no write.
        ld_addr = 32'h0000_01C0;
        st_addr = 32'h0000_0044;
        ld_req  = 1'b0; st_req = 1'b0;
        @(negedge clk);
        chk("idle_addr", dmem_addr,    32'h0000_01C0);
        chk("idle_we",   32'(dmem_we), 32'h0);
        @(posedge clk);
        #1;

        // Starvation: forced drain on cycles 9 and 18 with continuous contention.
        ld_addr = 32'h0000_0100;
        st_addr = 32'h0000_0080;
        st_data = 32'hA5A5_A5A5;
        for (int c = 1; c <= 18; c++) begin
            if (c == 9 || c == 18) begin
                ld_req = 1'b1; st_req = 1'b1; stbuf_full = 1'b0; flush = 1'b0;
                @(negedge clk);
                chk($sformatf("starve%0d_addr", c), dmem_addr, 32'h0000_0080);
                @(posedge clk);
                #1;
                // Re-run the same cycle kind through cyc would advance time; checks above suffice
                // for the address, grants are checked on the neighbouring cycle below.
            end else begin
                cyc($sformatf("starve%0d", c), 1, 1, 0, 0, 1, 0, 0);
            end
        end

        // Full buffer: store always wins for three cycles.
        for (int c = 1; c <= 3; c++) begin
            cyc($sformatf("full%0d", c), 1, 1, 1, 0, 0, 1, 1);
        end

        // Flush: load grant and stall suppressed; stores still drain.
        cyc("flush_nost", 1, 0, 0, 1, 0, 0, 0);
        cyc("flush_st",   1, 1, 0, 1, 0, 0, 1);

        // Store withdrawn in S_WAIT restarts the starvation count.
        for (int c = 1; c <= 3; c++) cyc($sformatf("wdrop%0d", c), 1, 1, 0, 0, 1, 0, 0);
        cyc("wdrop_nost", 1, 0, 0, 0, 1, 0, 0);
        for (int c = 1; c <= 8; c++) cyc($sformatf("wre%0d", c), 1, 1, 0, 0, 1, 0, 0);
        cyc("wre_force", 1, 1, 0, 0, 0, 1, 1);

        // Store vanishes in S_FORCE: no grant, load proceeds, back to idle.
        for (int c = 1; c <= 8; c++) cyc($sformatf("van%0d", c), 1, 1, 0, 0, 1, 0, 0);
        cyc("van_force", 1, 0, 0, 0, 1, 0, 0);

        // Reset in S_FORCE: quiet during reset, full 8-cycle wait afterwards.
        for (int c = 1; c <= 8; c++) cyc($sformatf("rf%0d", c), 1, 1, 0, 0, 1, 0, 0);
        rst_n = 1'b0;
        cyc("rf_rst", 1, 1, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) cyc($sformatf("rfpost%0d", c), 1, 1, 0, 0, 1, 0, 0);
        cyc("rfpost_force", 1, 1, 0, 0, 0, 1, 1);
        cyc("rfpost_after", 1, 1, 0, 0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Grant/stall/ack checks for the forced-drain cycles of the starvation run.
    always @(negedge clk) begin
        if (rst_n && ld_req && st_req && !stbuf_full && !flush && dmem_addr == 32'h0000_0080
            && ld_addr == 32'h0000_0100 && st_addr == 32'h0000_0080) begin
            chk("force_gnt",   32'(ld_gnt),   32'h0);
            chk("force_stall", 32'(ld_stall), 32'h1);
            chk("force_ack",   32'(st_ack),   32'h1);
        end
    end

endmodule
`default_nettype wire
